// File: rtl/hevc_subpel_interp_pkg.sv
// Shared constants, select encodings and HEVC luma 8-tap coefficients for the
// 8x8 sub-pel interpolator; nothing here holds state.
package hevc_subpel_interp_pkg;

  localparam int WIN     = 15;
  localparam int BLK     = 8;
  localparam int MARGIN  = 3;
  localparam int PIXW    = 8;
  localparam int ROW_W   = WIN * PIXW;
  localparam int FIR_W   = BLK * PIXW;
  localparam int SLOT_W  = BLK * FIR_W;
  localparam int PLANE_W = 5 * SLOT_W;
  localparam int TMP_W   = BLK * ROW_W;

  localparam logic [7:0] CNT_COL_START  = 8'd15;
  localparam logic [7:0] CNT_VERT_START = 8'd16;
  localparam logic [7:0] CNT_VERT_END   = 8'd47;
  localparam logic [7:0] CNT_DONE       = 8'd48;

  typedef enum logic [1:0] {
    SRC_TEMP_A = 2'd0,
    SRC_TEMP_B = 2'd1,
    SRC_TEMP_C = 2'd2,
    SRC_INT    = 2'd3
  } src_sel_e;

  typedef enum logic [1:0] {
    COEF_QTR  = 2'd0,
    COEF_HALF = 2'd1,
    COEF_3QTR = 2'd2
  } coef_sel_e;

  // Tap i sits in byte i: QTR -1,4,-10,58,17,-5,1,0 ; HALF -1,4,-11,40,40,-11,4,-1 ; 3QTR is QTR mirrored.
  function automatic logic signed [7:0] coef_tap(input coef_sel_e set, input int tap);
    logic [63:0] taps;
    taps = '0;
    case (set)
      COEF_QTR:  taps = 64'h00_01_FB_11_3A_F6_04_FF;
      COEF_HALF: taps = 64'hFF_04_F5_28_28_F5_04_FF;
      COEF_3QTR: taps = 64'hFF_04_F6_3A_11_FB_01_00;
      default:   taps = '0;
    endcase
    return signed'(taps[tap*8 +: 8]);
  endfunction

endpackage

// File: rtl/hevc_fir8x8.sv
// 8-tap FIR producing 8 outputs from 15 samples, rounded (+32, >>>6) and clipped to 0..255.
// Purely combinational: zero latency, no flow control.
module hevc_fir8x8
  import hevc_subpel_interp_pkg::*;
(
  input  logic [ROW_W-1:0] px,
  input  coef_sel_e        coef_set,
  output logic [FIR_W-1:0] res
);

  always_comb begin
    logic signed [15:0] acc;
    logic signed [15:0] tap16;
    logic signed [15:0] pix16;
    logic signed [15:0] rnd;
    logic signed [7:0]  cf;
    acc   = '0;
    tap16 = '0;
    pix16 = '0;
    rnd   = '0;
    cf    = '0;
    res   = '0;
    for (int k = 0; k < BLK; k++) begin
      acc = '0;
      for (int i = 0; i < 8; i++) begin
        cf    = coef_tap(coef_set, i);
        tap16 = {{8{cf[7]}}, cf};
        pix16 = {8'h00, px[(k+i)*PIXW +: PIXW]};
        acc   = acc + tap16 * pix16;
      end
      // Worst-case |acc| is 255*112, so 16 signed bits never overflow.
      rnd = (acc + 16'sd32) >>> 6;
      if (rnd[15])
        res[k*PIXW +: PIXW] = 8'd0;
      else if (rnd > 16'sd255)
        res[k*PIXW +: PIXW] = 8'd255;
      else
        res[k*PIXW +: PIXW] = rnd[7:0];
    end
  end

endmodule

// File: rtl/hevc_subpel_interp.sv
// All 15 HEVC luma fractional positions for an 8x8 block from a 15x15 window, row pass then column pass.
// Latency: done (load_out) 48 clocks after reset; window rows must arrive same cycle, no backpressure.
module hevc_subpel_interp
  import hevc_subpel_interp_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ROW_W-1:0]     in_row,
  output logic [63:0]          next_row,
  output logic [PLANE_W-1:0]   out_A,
  output logic [PLANE_W-1:0]   out_B,
  output logic [PLANE_W-1:0]   out_C,
  output logic [7:0]           cnt,
  output logic [FIR_W-1:0]     fir_out_a,
  output logic [FIR_W-1:0]     fir_out_b,
  output logic [FIR_W-1:0]     fir_out_c,
  output logic [TMP_W-1:0]     temp_A,
  output logic [TMP_W-1:0]     temp_B,
  output logic [TMP_W-1:0]     temp_C,
  output logic                 load_out,
  output logic [7:0]           sel,
  output logic [ROW_W-1:0]     currentPixels
);

  logic [7:0]         cnt_q, cnt_d;
  logic [ROW_W-1:0]   cur_q, cur_d;
  logic [TMP_W-1:0]   temp_a_q, temp_a_d;
  logic [TMP_W-1:0]   temp_b_q, temp_b_d;
  logic [TMP_W-1:0]   temp_c_q, temp_c_d;
  logic [TMP_W-1:0]   int_q, int_d;
  logic [PLANE_W-1:0] out_a_q, out_a_d;
  logic [PLANE_W-1:0] out_b_q, out_b_d;
  logic [PLANE_W-1:0] out_c_q, out_c_d;

  hevc_fir8x8 u_fir_a (.px(cur_q), .coef_set(COEF_QTR),  .res(fir_out_a));
  hevc_fir8x8 u_fir_b (.px(cur_q), .coef_set(COEF_HALF), .res(fir_out_b));
  hevc_fir8x8 u_fir_c (.px(cur_q), .coef_set(COEF_3QTR), .res(fir_out_c));

  always_comb begin
    int       row_idx;
    int       col_idx;
    int       base;
    logic [4:0] col_step;
    logic [4:0] vstep;
    cnt_d    = cnt_q;
    cur_d    = cur_q;
    temp_a_d = temp_a_q;
    temp_b_d = temp_b_q;
    temp_c_d = temp_c_q;
    int_d    = int_q;
    out_a_d  = out_a_q;
    out_b_d  = out_b_q;
    out_c_d  = out_c_q;
    row_idx  = 0;
    col_idx  = 0;
    base     = 0;
    col_step = '0;
    vstep    = '0;

    if (cnt_q != CNT_DONE)
      cnt_d = cnt_q + 8'd1;

    if (cnt_q < CNT_COL_START)
      cur_d = in_row;

    if (cnt_q >= 8'd1 && cnt_q <= CNT_COL_START) begin
      row_idx = int'(cnt_q) - 1;
      for (int k = 0; k < BLK; k++) begin
        temp_a_d[k*ROW_W + row_idx*PIXW +: PIXW] = fir_out_a[k*PIXW +: PIXW];
        temp_b_d[k*ROW_W + row_idx*PIXW +: PIXW] = fir_out_b[k*PIXW +: PIXW];
        temp_c_d[k*ROW_W + row_idx*PIXW +: PIXW] = fir_out_c[k*PIXW +: PIXW];
        int_d[k*ROW_W + row_idx*PIXW +: PIXW]    = cur_q[(MARGIN+k)*PIXW +: PIXW];
      end
      if (row_idx >= MARGIN && row_idx < MARGIN + BLK) begin
        out_a_d[(row_idx-MARGIN)*FIR_W +: FIR_W] = fir_out_a;
        out_b_d[(row_idx-MARGIN)*FIR_W +: FIR_W] = fir_out_b;
        out_c_d[(row_idx-MARGIN)*FIR_W +: FIR_W] = fir_out_c;
      end
    end

    // Column 0 of temp_A is fetched in the same cycle its last row is written, so read the _d copies.
    if (cnt_q >= CNT_COL_START && cnt_q < CNT_VERT_END) begin
      col_step = 5'(cnt_q - CNT_COL_START);
      col_idx  = int'(col_step[2:0]);
      case (src_sel_e'(col_step[4:3]))
        SRC_TEMP_A: cur_d = temp_a_d[col_idx*ROW_W +: ROW_W];
        SRC_TEMP_B: cur_d = temp_b_d[col_idx*ROW_W +: ROW_W];
        SRC_TEMP_C: cur_d = temp_c_d[col_idx*ROW_W +: ROW_W];
        SRC_INT:    cur_d = int_d[col_idx*ROW_W +: ROW_W];
      endcase
    end

    if (cnt_q >= CNT_VERT_START && cnt_q <= CNT_VERT_END) begin
      vstep   = 5'(cnt_q - CNT_VERT_START);
      col_idx = int'(vstep[2:0]);
      for (int y = 0; y < BLK; y++) begin
        base = y*FIR_W + col_idx*PIXW;
        case (src_sel_e'(vstep[4:3]))
          SRC_TEMP_A: begin
            out_a_d[1*SLOT_W + base +: PIXW] = fir_out_a[y*PIXW +: PIXW];
            out_a_d[2*SLOT_W + base +: PIXW] = fir_out_b[y*PIXW +: PIXW];
            out_a_d[3*SLOT_W + base +: PIXW] = fir_out_c[y*PIXW +: PIXW];
          end
          SRC_TEMP_B: begin
            out_b_d[1*SLOT_W + base +: PIXW] = fir_out_a[y*PIXW +: PIXW];
            out_b_d[2*SLOT_W + base +: PIXW] = fir_out_b[y*PIXW +: PIXW];
            out_b_d[3*SLOT_W + base +: PIXW] = fir_out_c[y*PIXW +: PIXW];
          end
          SRC_TEMP_C: begin
            out_c_d[1*SLOT_W + base +: PIXW] = fir_out_a[y*PIXW +: PIXW];
            out_c_d[2*SLOT_W + base +: PIXW] = fir_out_b[y*PIXW +: PIXW];
            out_c_d[3*SLOT_W + base +: PIXW] = fir_out_c[y*PIXW +: PIXW];
          end
          SRC_INT: begin
            out_a_d[4*SLOT_W + base +: PIXW] = fir_out_a[y*PIXW +: PIXW];
            out_b_d[4*SLOT_W + base +: PIXW] = fir_out_b[y*PIXW +: PIXW];
            out_c_d[4*SLOT_W + base +: PIXW] = fir_out_c[y*PIXW +: PIXW];
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      cur_q    <= '0;
      temp_a_q <= '0;
      temp_b_q <= '0;
      temp_c_q <= '0;
      int_q    <= '0;
      out_a_q  <= '0;
      out_b_q  <= '0;
      out_c_q  <= '0;
    end else begin
      cnt_q    <= cnt_d;
      cur_q    <= cur_d;
      temp_a_q <= temp_a_d;
      temp_b_q <= temp_b_d;
      temp_c_q <= temp_c_d;
      int_q    <= int_d;
      out_a_q  <= out_a_d;
      out_b_q  <= out_b_d;
      out_c_q  <= out_c_d;
    end
  end

  assign next_row      = {56'd0, (cnt_q < CNT_COL_START) ? cnt_q : 8'(WIN - 1)};
  assign sel           = (cnt_q >= CNT_VERT_START && cnt_q <= CNT_VERT_END) ? (cnt_q - CNT_VERT_START) : 8'd0;
  assign load_out      = (cnt_q == CNT_DONE);
  assign cnt           = cnt_q;
  assign currentPixels = cur_q;
  assign temp_A        = temp_a_q;
  assign temp_B        = temp_b_q;
  assign temp_C        = temp_c_q;
  assign out_A         = out_a_q;
  assign out_B         = out_b_q;
  assign out_C         = out_c_q;

endmodule

// File: tb/tb_hevc_subpel_interp.sv
// Scoreboard bench: each window's expected planes come from a plain-integer 2-D filter model and are
// compared by an independent monitor when load_out rises; control outputs are checked per cycle.
module tb_hevc_subpel_interp;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [119:0]  in_row = '0;
  logic [63:0]   next_row;
  logic [2559:0] out_A, out_B, out_C;
  logic [7:0]    cnt;
  logic [63:0]   fir_out_a, fir_out_b, fir_out_c;
  logic [959:0]  temp_A, temp_B, temp_C;
  logic          load_out;
  logic [7:0]    sel;
  logic [119:0]  currentPixels;

  always #5 clk = ~clk;

  hevc_subpel_interp dut (
    .clk(clk), .rst(rst), .in_row(in_row), .next_row(next_row),
    .out_A(out_A), .out_B(out_B), .out_C(out_C), .cnt(cnt),
    .fir_out_a(fir_out_a), .fir_out_b(fir_out_b), .fir_out_c(fir_out_c),
    .temp_A(temp_A), .temp_B(temp_B), .temp_C(temp_C),
    .load_out(load_out), .sel(sel), .currentPixels(currentPixels)
  );

  typedef struct {
    string         name;
    logic [2559:0] pa;
    logic [2559:0] pb;
    logic [2559:0] pc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   win [15][15];
  int   coef_tab [3][8] = '{'{-1, 4, -10, 58, 17, -5, 1, 0},
                            '{-1, 4, -11, 40, 40, -11, 4, -1},
                            '{0, 1, -5, 17, 58, -10, 4, -1}};

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int fir(input int p[15], input int set, input int k);
    int sum = 0;
    int v;
    for (int i = 0; i < 8; i++) sum += coef_tab[set][i] * p[k+i];
    v = (sum + 32) >>> 6;
    if (v < 0) v = 0;
    if (v > 255) v = 255;
    return v;
  endfunction

  // Reference: filter every window row, then every column of each filtered plane and of the block itself.
  task automatic build_expected(output logic [2559:0] pa, output logic [2559:0] pb, output logic [2559:0] pc);
    int h [3][15][8];
    int e [3][5][8][8];
    int p [15];
    logic [2559:0] pl [3];
    for (int r = 0; r < 15; r++) begin
      for (int c = 0; c < 15; c++) p[c] = win[r][c];
      for (int x = 0; x < 3; x++)
        for (int k = 0; k < 8; k++) h[x][r][k] = fir(p, x, k);
    end
    for (int x = 0; x < 3; x++)
      for (int y = 0; y < 8; y++)
        for (int k = 0; k < 8; k++) e[x][0][y][k] = h[x][y+3][k];
    for (int x = 0; x < 3; x++)
      for (int k = 0; k < 8; k++) begin
        for (int r = 0; r < 15; r++) p[r] = h[x][r][k];
        for (int f = 0; f < 3; f++)
          for (int y = 0; y < 8; y++) e[x][1+f][y][k] = fir(p, f, y);
      end
    for (int k = 0; k < 8; k++) begin
      for (int r = 0; r < 15; r++) p[r] = win[r][3+k];
      for (int f = 0; f < 3; f++)
        for (int y = 0; y < 8; y++) e[f][4][y][k] = fir(p, f, y);
    end
    for (int x = 0; x < 3; x++) begin
      pl[x] = '0;
      for (int s = 0; s < 5; s++)
        for (int y = 0; y < 8; y++)
          for (int k = 0; k < 8; k++) pl[x][((s*8+y)*64 + k*8) +: 8] = 8'(e[x][s][y][k]);
    end
    pa = pl[0];
    pb = pl[1];
    pc = pl[2];
  endtask

  function automatic logic [119:0] row_bits(input int r);
    logic [119:0] v = '0;
    for (int c = 0; c < 15; c++) v[c*8 +: 8] = 8'(win[r][c]);
    return v;
  endfunction

  task automatic fill(input int pat);
    for (int r = 0; r < 15; r++)
      for (int c = 0; c < 15; c++)
        case (pat)
          0: win[r][c] = 100;
          1: win[r][c] = 8 * c;
          2: win[r][c] = 8 * r;
          3: win[r][c] = (c == 3) ? 255 : 0;
          4: win[r][c] = ((r + c) % 2 == 1) ? 255 : 0;
          default: win[r][c] = int'($urandom_range(0, 255));
        endcase
  endtask

  task automatic check_ctl(input string name, input int t);
    int nr = (t < 15) ? t : 14;
    int sl = (t >= 16 && t <= 47) ? t - 16 : 0;
    logic [87:0] exp_v = {64'(nr), 8'(sl), 8'(t), 7'b0, (t == 48)};
    check($sformatf("%s ctl t=%0d", name, t), 512'({next_row, sel, cnt, 7'b0, load_out}), 512'(exp_v));
  endtask

  task automatic run_window(input string name, input int abort_at);
    exp_t e;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check({name, " reset planes"}, 512'({|out_A, |out_B, |out_C}), '0);
    check({name, " reset internals"},
          512'({|temp_A, |temp_B, |temp_C, |currentPixels, |fir_out_a, |fir_out_b, |fir_out_c}), '0);
    e.name = name;
    e.pa = '0;
    e.pb = '0;
    e.pc = '0;
    if (abort_at < 0) begin
      build_expected(e.pa, e.pb, e.pc);
      sb.push_back(e);
    end
    for (int t = 0; t <= 48; t++) begin
      if (t == abort_at) return;
      check_ctl(name, t);
      in_row = (next_row < 64'd15) ? row_bits(int'(next_row[3:0])) : '0;
      @(negedge clk);
    end
    in_row = 120'(32'($urandom));
    repeat (3) @(negedge clk);
    check_ctl({name, " hold"}, 48);
    check({name, " hold A slot4"}, out_A[4*512 +: 512], e.pa[4*512 +: 512]);
  endtask

  initial begin : monitor
    exp_t e;
    logic done_prev;
    done_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (load_out && !done_prev) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected done: load_out rose with empty scoreboard");
        end else begin
          e = sb.pop_front();
          for (int s = 0; s < 5; s++) begin
            check($sformatf("%s A slot%0d", e.name, s), out_A[s*512 +: 512], e.pa[s*512 +: 512]);
            check($sformatf("%s B slot%0d", e.name, s), out_B[s*512 +: 512], e.pb[s*512 +: 512]);
            check($sformatf("%s C slot%0d", e.name, s), out_C[s*512 +: 512], e.pc[s*512 +: 512]);
          end
        end
      end
      done_prev = load_out;
    end
  end

  initial begin : stimulus
    string names [5] = '{"flat", "hramp", "vramp", "impulse", "checker"};
    @(negedge clk);
    fill(0);
    run_window("flat_abort", 20);
    for (int p = 0; p < 5; p++) begin
      fill(p);
      run_window(names[p], -1);
    end
    for (int n = 0; n < 4; n++) begin
      fill(5);
      run_window($sformatf("random%0d", n), -1);
    end
    @(negedge clk);
    check("scoreboard drained", 512'(sb.size()), '0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
